add_seq_arbiter: RTL
====================

ADD_SEQ_ARBITER -- requirements
Module: add_seq_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits, legal range 2..32.
REQ-002 wb_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operand pair pending.
REQ-005 req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-006 req0_ready  output  1  requester 0 accepted this cycle; transfer occurs on valid&ready.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  same directions, widths and meanings as REQ-004..006, for requester 1.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_id  output  1  requester that owns the result (0 or 1).
REQ-010 rsp_sum  output  WIDTH  sum bits.
REQ-011 rsp_cout  output  1  carry out of the MSB.
REQ-012 rsp_ready  input  1  consumer takes the result on rsp_valid&rsp_ready.
REQ-013 add_c_sel, add_in_xor, add_in_and, add_cin  output  1 each  drive the shared 1-bit adder cell.
REQ-014 add_sum, add_cout  input  1 each  adder cell outputs, combinational from the REQ-013 signals within the same cycle.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
REQ-016 IDLE: with at least one reqN_valid high, the controller SHALL grant one requester, assert only its reqN_ready that cycle, latch its a, b and id, clear bit index and carry, and move to RUN.
REQ-017 Arbitration SHALL be round-robin: one requester valid -> it wins; both valid -> the requester not granted last wins; last-grant pointer updates on every accept.
REQ-018 reqN_ready SHALL be 0 in RUN and DONE, and 0 for the non-granted requester in IDLE.
REQ-019 RUN, bit index i = 0..WIDTH-1, one bit per cycle, LSB first: add_in_xor = a[i]^b[i], add_in_and = a[i]&b[i], add_cin = carry register, add_c_sel = 1.
REQ-020 RUN, each cycle: result[i] <= add_sum, carry <= add_cout, i <= i+1; after bit WIDTH-1 -> DONE.
REQ-021 Latency: accept at cycle T, RUN occupies T+1..T+WIDTH, rsp_valid first high at T+WIDTH+1.
REQ-022 DONE: rsp_valid = 1; rsp_sum = result; rsp_cout = final carry; rsp_id = latched id; all held stable until rsp_ready.
REQ-023 DONE with rsp_ready = 1 -> IDLE next cycle; no request is accepted in that same cycle.
REQ-024 Outside RUN: add_in_xor = add_in_and = add_cin = 0; add_c_sel = 1 at all times.
REQ-025 Requests arriving during RUN/DONE SHALL wait (no drop); requester operands are sampled only at accept.
REQ-026 Wrap-around: the sum is modulo 2^WIDTH, with overflow reported only on rsp_cout.

Reset
REQ-027 When wb_rst_i = 1 at a clock edge, the following cycle SHALL be: state IDLE, rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_cout = 0, reqN_ready = 0, carry = 0, bit index = 0, last-grant = 1 (req0 wins the first tie).
REQ-028 Reset during RUN or DONE SHALL abandon the operation: no response is ever issued for it, and the requester must re-present.
REQ-029 While wb_rst_i is high no request SHALL be accepted.

Verification (bench supplies a combinational 1-bit full-adder model on add_*)
REQ-030 After reset, req0 with a=8'h5A, b=8'h33 -> req0_ready pulse at T; rsp_valid at T+9 with sum=8'h8D, cout=0, id=0.
REQ-031 req1 with a=8'hFF, b=8'h01 -> sum=8'h00, cout=1, id=1.
REQ-032 Both valid continuously from reset with rsp_ready=1 -> grants alternate 0,1,0,1; each accept is 10 cycles after the previous one.
REQ-033 rsp_ready held 0 for 5 cycles in DONE -> rsp_valid/rsp_sum/rsp_cout/rsp_id stable, both reqN_ready = 0; exactly one response is delivered when rsp_ready rises.
REQ-034 wb_rst_i pulsed while bit index = 3 in RUN -> next cycle IDLE with all outputs at reset values; no rsp_valid for that operation.
REQ-035 1000 random operand pairs per requester, random valid/ready gaps, WIDTH=8 and WIDTH=32 -> every response matches {cout,sum} = a+b, with no loss or duplication.

Source files
------------

// File: rtl/add_seq_arbiter_if.sv
// Request/response/adder-cell bundle for the two-requester bit-serial adder.
interface add_seq_arbiter_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;

    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
    logic             rsp_ready;

    logic             add_c_sel;
    logic             add_in_xor;
    logic             add_in_and;
    logic             add_cin;
    logic             add_sum;
    logic             add_cout;

    // Controller side
    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout,
        input  rsp_ready,
        output add_c_sel, add_in_xor, add_in_and, add_cin,
        input  add_sum, add_cout
    );

    // Requester / consumer / adder-cell side
    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
        output rsp_ready,
        input  add_c_sel, add_in_xor, add_in_and, add_cin,
        output add_sum, add_cout
    );
endinterface

// File: rtl/add_seq_arbiter.sv
// Round-robin arbiter in front of a bit-serial adder built on one external
// full-adder cell: one bit per cycle, LSB first, result held until taken.
module add_seq_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    add_seq_arbiter_if.slave  bus
);
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic             owner;
    logic             last_grant;
    logic             rsp_valid_q;

    logic             pick1_c;
    logic             idle_c;
    logic             run_c;

    // Requester 1 wins when it is alone, or on a tie when requester 0 went last
    assign pick1_c = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    assign idle_c  = (state == IDLE) & ~wb_rst_i;
    assign run_c   = (state == RUN);

    // Ready is a same-cycle grant so an accept happens on the first IDLE cycle
    assign bus.req0_ready = idle_c & bus.req0_valid & ~pick1_c;
    assign bus.req1_ready = idle_c & pick1_c;

    // Adder cell operands for the current bit; quiet outside RUN
    assign bus.add_c_sel  = 1'b1;
    assign bus.add_in_xor = run_c & (op_a[idx] ^ op_b[idx]);
    assign bus.add_in_and = run_c & (op_a[idx] & op_b[idx]);
    assign bus.add_cin    = run_c & carry;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = owner;
    assign bus.rsp_sum   = result;
    assign bus.rsp_cout  = carry;

    // Controller: accept/arbitrate, serial add, hold result until consumed
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            result      <= '0;
            carry       <= 1'b0;
            idx         <= '0;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0_valid | bus.req1_valid) begin
                        op_a       <= pick1_c ? bus.req1_a : bus.req0_a;
                        op_b       <= pick1_c ? bus.req1_b : bus.req0_b;
                        owner      <= pick1_c;
                        last_grant <= pick1_c;
                        idx        <= '0;
                        carry      <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    result[idx] <= bus.add_sum;
                    carry       <= bus.add_cout;
                    if (idx == LAST_IDX) begin
                        idx         <= '0;
                        rsp_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule
